audio_frame_reader: RTL and testbench

AUDIO_FRAME_READER -- requirements
Module: audio_frame_reader

---
 rtl/audio_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_audio_frame_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_reader.sv
// Streams a processed audio frame out of a synchronous-read line memory as 16-bit samples.
// Optional macro AUDIO_FRAME_READER_PREFETCH_EN adds a prefetch line buffer for gap-free streaming.
module audio_frame_reader #(
  parameter int LINES            = 64,
  parameter int SAMPLES_PER_LINE = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic [5:0]   output_index,
  input  logic [511:0] data_out,
  output logic [15:0]  sample_out,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic [10:0]  sample_count,
  output logic         busy,
  output logic         done,
  output logic [2:0]   state_dbg
);

  localparam int        KW       = (SAMPLES_PER_LINE > 1) ? $clog2(SAMPLES_PER_LINE) : 1;
  localparam logic [5:0] LAST_IDX = 6'(LINES - 1);
  localparam logic [KW-1:0] LAST_K = KW'(SAMPLES_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [511:0]    line_buf;
  logic [KW-1:0]   k;
  logic            hs;
  logic            last_k;
  logic            more_lines;

`ifdef AUDIO_FRAME_READER_PREFETCH_EN
  logic [511:0]    pf_buf;
  logic [1:0]      pf_pipe;   // tracks the memory's one-cycle read latency after an index change
  logic            pf_valid;
  logic [5:0]      cur_line;  // output_index runs one line ahead of the line being streamed

  assign more_lines   = (cur_line < LAST_IDX);
  // A line switch cannot happen before its successor has landed in the prefetch buffer.
  assign sample_valid = (state_q == S_STREAM) && !(last_k && more_lines && !pf_valid);
`else
  assign more_lines   = (output_index < LAST_IDX);
  assign sample_valid = (state_q == S_STREAM);
`endif

  // Handshake: a sample transfers on any rising edge where sample_valid and sample_ready are both high.
  assign hs         = sample_valid && sample_ready;
  assign last_k     = (k == LAST_K);
  assign sample_out = line_buf[{k, 4'b0000} +: 16];
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign state_dbg  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_FETCH;
        S_FETCH:  state_d = S_LOAD;
        S_LOAD:   state_d = S_STREAM;
        S_STREAM: begin
          if (hs && last_k) begin
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
            state_d = more_lines ? S_STREAM : S_DONE;
`else
            state_d = more_lines ? S_FETCH : S_DONE;
`endif
          end
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_index <= '0;
      sample_count <= '0;
      line_buf     <= '0;
      k            <= '0;
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
      pf_buf       <= '0;
      pf_pipe      <= '0;
      pf_valid     <= 1'b0;
      cur_line     <= '0;
`endif
    end else if (abort && state_q != S_IDLE) begin
      output_index <= '0;
      k            <= '0;
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
      pf_pipe      <= '0;
      pf_valid     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            output_index <= '0;
            sample_count <= '0;
            k            <= '0;
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
            cur_line     <= '0;
            pf_pipe      <= '0;
            pf_valid     <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          line_buf <= data_out;
          k        <= '0;
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
          if (output_index < LAST_IDX) begin
            output_index <= output_index + 6'd1;
            pf_pipe      <= 2'b01;
          end
`endif
        end
        S_STREAM: begin
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
          pf_pipe <= {pf_pipe[0], 1'b0};
          if (pf_pipe[1]) begin
            pf_buf   <= data_out;
            pf_valid <= 1'b1;
          end
`endif
          if (hs) begin
            sample_count <= sample_count + 11'd1;
            k            <= k + KW'(1);
            if (last_k) begin
              k <= '0;
`ifdef AUDIO_FRAME_READER_PREFETCH_EN
              if (more_lines) begin
                line_buf <= pf_buf;
                cur_line <= cur_line + 6'd1;
                pf_valid <= 1'b0;
                if (output_index < LAST_IDX) begin
                  output_index <= output_index + 6'd1;
                  pf_pipe      <= 2'b01;
                end
              end
`else
              if (more_lines) output_index <= output_index + 6'd1;
`endif
            end
          end
        end
        S_DONE: output_index <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_reader.sv
// Directed bench for audio_frame_reader: full frames, stalls, restart-ignore, abort and mid-frame reset.
module tb_audio_frame_reader;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [5:0]   output_index;
  logic [511:0] data_out;
  logic [15:0]  sample_out;
  logic         sample_valid;
  logic         sample_ready;
  logic [10:0]  sample_count;
  logic         busy;
  logic         done;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_n  = 0;
  int done_seen = 0;

`ifdef AUDIO_FRAME_READER_PREFETCH_EN
  localparam int EXP_GAP = 0;
  localparam bit PF      = 1'b1;
`else
  localparam int EXP_GAP = 2;
  localparam bit PF      = 1'b0;
`endif

  audio_frame_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .output_index (output_index),
    .data_out     (data_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_count (sample_count),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor memory model: line n holds samples 32n..32n+31, one-cycle read latency.
  function automatic logic [511:0] line_data(input logic [5:0] n);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 32; j++) v[j*16 +: 16] = 16'(int'(n) * 32 + j);
    return v;
  endfunction

  always @(posedge clk) data_out <= line_data(output_index);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_index(input int n);
    int line;
    line = n / 32;
    if (PF && line < 63) return line + 1;
    return line;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_index"}, output_index, 0);
    check({tag, "_sample"}, sample_out, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_count"}, sample_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    sample_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("fetch_busy", busy, 1);
    check("fetch_valid", sample_valid, 0);
    check("fetch_index", output_index, 0);
    check("fetch_count", sample_count, 0);
    @(negedge clk);
    check("load_busy", busy, 1);
    check("load_valid", sample_valid, 0);
    @(negedge clk);
    check("first_valid", sample_valid, 1);
    check("first_sample", sample_out, 0);
  endtask

  // Drives sample_ready and checks every presented sample; stops once sample stop_at is shown
  // (left un-accepted) or, for stop_at=2048, right after the final handshake is set up.
  task automatic stream(input int stop_at, input bit rnd, input int restart_at);
    int cyc;
    int gap;
    bit in_gap;
    bit stalled;
    logic [15:0] held;
    cyc = 0; gap = 0; in_gap = 0; stalled = 0; held = '0;
    done_seen = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc > 20000) begin
        checks++; errors++;
        $error("FAIL stream_timeout: observed %0d cycles expected below 20000", cyc);
        break;
      end
      if (done) done_seen++;
      if (sample_valid) begin
        if (in_gap) begin
          check("line_gap", gap, EXP_GAP);
          in_gap = 0;
          gap = 0;
        end
        if (stalled) check("stall_hold", sample_out, held);
        check("sample", sample_out, exp_n);
        check("count", sample_count, exp_n);
        check("index", output_index, exp_index(exp_n));
        if (exp_n == stop_at) begin
          sample_ready = 1'b0;
          break;
        end
        sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (exp_n == restart_at) start = 1'b1;
        if (sample_ready) begin
          exp_n++;
          stalled = 0;
          if (exp_n == 2048) break;
        end else begin
          stalled = 1;
          held = sample_out;
        end
      end else begin
        sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (exp_n > 0 && exp_n % 32 == 0) begin
          in_gap = 1;
          gap++;
        end else begin
          checks++; errors++;
          $error("FAIL unexpected_invalid: observed valid 0 at sample %0d expected 1", exp_n);
        end
      end
    end
    check("no_early_done", done_seen, 0);
  endtask

  task automatic finish_frame();
    @(negedge clk);
    sample_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_valid", sample_valid, 0);
    @(negedge clk);
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("after_index", output_index, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle: abort and no start must leave the block idle.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_valid", sample_valid, 0);

    // Full frame with ready high; a second start at sample 100 is ignored.
    exp_n = 0;
    do_start();
    stream(2048, 1'b0, 100);
    finish_frame();

    // Full frame with pseudo-random back-pressure.
    exp_n = 0;
    do_start();
    stream(2048, 1'b1, -1);
    finish_frame();

    // Abort at sample 500, racing a handshake in the same cycle.
    exp_n = 0;
    do_start();
    stream(500, 1'b0, -1);
    sample_ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sample_ready = 1'b0;
    check("abort_valid", sample_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    // Restart from sample 0, then reset mid-frame at sample 1000.
    exp_n = 0;
    do_start();
    stream(1000, 1'b1, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", busy, 0);
    end

    exp_n = 0;
    do_start();
    stream(2048, 1'b0, -1);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
